// File: rtl/ram_access_ctrl_pkg.sv
// Shared types and defaults for the RAM access controller: FSM state
// encoding, strobe selection and the timer width helper.
package ram_access_pkg;

    localparam int RAM_ADDR_W = 8;
    localparam int RAM_DATA_W = 16;

    // VSTROBE/VHOLD are only reached when the write-verify option is built in.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        HOLD    = 3'd3,
        DONE    = 3'd4,
        VSTROBE = 3'd5,
        VHOLD   = 3'd6
    } state_t;

    // Which RAM strobe is asserted in the coming cycle.
    typedef enum logic [1:0] {
        STB_NONE = 2'd0,
        STB_WE   = 2'd1,
        STB_RE   = 2'd2
    } strobe_sel_t;

    // Down-counter width able to hold the longer of the two phase lengths.
    function automatic int timer_width(input int a, input int b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/ram_access_ctrl_timer.sv
// access_timer: loadable down-counter with terminal-count flag. Loaded
// with (phase length - 1) on entry to a phase, so o_tc is high in the
// last cycle of that phase.
module access_timer #(
    parameter int W = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    // Count down to zero and park there until the next load.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: valid/ready front end for a strobe-latched 256x16 RAM.
// Every mem_* and resp_* output is a flop loaded from the next-state
// decode, so strobe edges are glitch-free and address/data/cs are stable
// SETUP_CYC cycles before a strobe rises and one HOLD cycle after it falls.
// Optional build macro: RAM_ACCESS_CTRL_WR_VERIFY_EN adds a read-back of
// every write and flags a data mismatch on o_resp_err.
module ram_access_ctrl
    import ram_access_pkg::*;
#(
    parameter int ADDR_W     = RAM_ADDR_W,
    parameter int DATA_W     = RAM_DATA_W,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_wr,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_resp_valid,
    output logic [DATA_W-1:0] o_resp_rdata,
    output logic              o_resp_err,
    output logic              o_mem_cs,
    output logic              o_mem_we,
    output logic              o_mem_re,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_data,
    input  logic [DATA_W-1:0] i_mem_q
);

    localparam int                 CNT_W     = timer_width(SETUP_CYC, STROBE_CYC);
    localparam logic [CNT_W-1:0]   SETUP_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0]   STROBE_LD = CNT_W'(STROBE_CYC - 1);

    state_t             r_state;
    state_t             w_next;
    strobe_sel_t        w_stb;
    logic               w_cs_next;
    logic               w_accept;
    logic               w_load;
    logic [CNT_W-1:0]   w_load_val;
    logic               w_tc;

    logic               r_wr;
    logic               r_mem_cs;
    logic               r_mem_we;
    logic               r_mem_re;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_data;
    logic [DATA_W-1:0]  r_resp_rdata;
    logic               r_resp_valid;

    assign w_accept    = (r_state == IDLE) && i_req_valid;
    assign o_req_ready = (r_state == IDLE);

    // Phase timer, reloaded on every state change.
    access_timer #(
        .W (CNT_W)
    ) u_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_tc       (w_tc)
    );

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state, timer load and next-cycle strobe/cs decode.
    always_comb begin
        w_next     = r_state;
        w_stb      = STB_NONE;
        w_cs_next  = 1'b0;
        w_load     = 1'b0;
        w_load_val = '0;

        case (r_state)
            IDLE:    if (i_req_valid) w_next = SETUP;
            SETUP:   if (w_tc) w_next = STROBE;
            STROBE:  if (w_tc) w_next = HOLD;
`ifdef RAM_ACCESS_CTRL_WR_VERIFY_EN
            HOLD:    w_next = r_wr ? VSTROBE : DONE;
            VSTROBE: if (w_tc) w_next = VHOLD;
            VHOLD:   w_next = DONE;
`else
            HOLD:    w_next = DONE;
`endif
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase

        w_load = (w_next != r_state);
        case (w_next)
            SETUP:           w_load_val = SETUP_LD;
            STROBE, VSTROBE: w_load_val = STROBE_LD;
            default:         w_load_val = '0;
        endcase

        // r_wr is already latched whenever STROBE is entered (from SETUP).
        case (w_next)
            STROBE:  w_stb = r_wr ? STB_WE : STB_RE;
            VSTROBE: w_stb = STB_RE;
            default: w_stb = STB_NONE;
        endcase

        w_cs_next = (w_next == SETUP) || (w_next == STROBE) || (w_next == HOLD) ||
                    (w_next == VSTROBE) || (w_next == VHOLD);
    end

    // RAM-side flops: strobes and cs follow the next state; address and data
    // are loaded only on acceptance so they never move during an access.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr       <= 1'b0;
            r_mem_cs   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_re   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
        end else begin
            r_mem_cs <= w_cs_next;
            r_mem_we <= (w_stb == STB_WE);
            r_mem_re <= (w_stb == STB_RE);
            if (w_accept) begin
                r_wr       <= i_req_wr;
                r_mem_addr <= i_req_addr;
                r_mem_data <= i_req_wdata;
            end
        end
    end

    // Response flops: read data is taken at the end of HOLD, and the
    // completion pulse is registered out of DONE.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_resp_rdata <= '0;
            r_resp_valid <= 1'b0;
        end else begin
            r_resp_valid <= (r_state == DONE);
            if ((r_state == HOLD) && !r_wr) begin
                r_resp_rdata <= i_mem_q;
            end
        end
    end

`ifdef RAM_ACCESS_CTRL_WR_VERIFY_EN
    logic r_vfail;
    logic r_resp_err;

    // Verify read-back: compare in VHOLD, report alongside the completion pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vfail    <= 1'b0;
            r_resp_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_vfail <= 1'b0;
            end else if (r_state == VHOLD) begin
                r_vfail <= (i_mem_q != r_mem_data);
            end
            r_resp_err <= (r_state == DONE) && r_vfail;
        end
    end

    assign o_resp_err = r_resp_err;
`else
    assign o_resp_err = 1'b0;
`endif

    assign o_mem_cs     = r_mem_cs;
    assign o_mem_we     = r_mem_we;
    assign o_mem_re     = r_mem_re;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_data   = r_mem_data;
    assign o_resp_rdata = r_resp_rdata;
    assign o_resp_valid = r_resp_valid;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl: two instances (default timing and a
// SETUP_CYC=3/STROBE_CYC=1 build), each driving a behavioural strobe-latched
// RAM. Expected timelines come from the phase lengths; expected data comes
// from a shadow memory array.
module tb_ram_access_ctrl;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int S0 = 1;
    localparam int T0 = 2;
    localparam int S1 = 3;
    localparam int T1 = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]         valid = '0;
    logic [1:0]         wr    = '0;
    logic [1:0][AW-1:0] addr  = '0;
    logic [1:0][DW-1:0] wd    = '0;

    logic          a_ready, a_rv, a_err, a_cs, a_we, a_re;
    logic          b_ready, b_rv, b_err, b_cs, b_we, b_re;
    logic [AW-1:0] a_maddr, b_maddr;
    logic [DW-1:0] a_mdata, b_mdata, a_rdata, b_rdata;
    logic [DW-1:0] q0 = '0;
    logic [DW-1:0] q1 = '0;

    logic [DW-1:0] ram0 [256] = '{default: '0};
    logic [DW-1:0] ram1 [256] = '{default: '0};
    logic [DW-1:0] model [2][256] = '{default: '0};
    bit            stuck0 = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [1:0]         v_rdy, v_rv, v_err, v_cs, v_we, v_re;
    logic [1:0][AW-1:0] v_maddr;
    logic [1:0][DW-1:0] v_mdata, v_rdata;
    assign v_rdy   = {b_ready, a_ready};
    assign v_rv    = {b_rv, a_rv};
    assign v_err   = {b_err, a_err};
    assign v_cs    = {b_cs, a_cs};
    assign v_we    = {b_we, a_we};
    assign v_re    = {b_re, a_re};
    assign v_maddr = {b_maddr, a_maddr};
    assign v_mdata = {b_mdata, a_mdata};
    assign v_rdata = {b_rdata, a_rdata};

    ram_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .SETUP_CYC(S0), .STROBE_CYC(T0)) u_dut0 (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(valid[0]), .o_req_ready(a_ready), .i_req_wr(wr[0]),
        .i_req_addr(addr[0]), .i_req_wdata(wd[0]),
        .o_resp_valid(a_rv), .o_resp_rdata(a_rdata), .o_resp_err(a_err),
        .o_mem_cs(a_cs), .o_mem_we(a_we), .o_mem_re(a_re),
        .o_mem_addr(a_maddr), .o_mem_data(a_mdata), .i_mem_q(q0)
    );

    ram_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .SETUP_CYC(S1), .STROBE_CYC(T1)) u_dut1 (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(valid[1]), .o_req_ready(b_ready), .i_req_wr(wr[1]),
        .i_req_addr(addr[1]), .i_req_wdata(wd[1]),
        .o_resp_valid(b_rv), .o_resp_rdata(b_rdata), .o_resp_err(b_err),
        .o_mem_cs(b_cs), .o_mem_we(b_we), .o_mem_re(b_re),
        .o_mem_addr(b_maddr), .o_mem_data(b_mdata), .i_mem_q(q1)
    );

    // RAM devices: latch on rising strobe edges; ram0 can model bit0 stuck-at-0.
    always @(posedge a_we) ram0[a_maddr] = stuck0 ? (a_mdata & 16'hFFFE) : a_mdata;
    always @(posedge a_re) q0 = ram0[a_maddr];
    always @(posedge b_we) ram1[b_maddr] = b_mdata;
    always @(posedge b_re) q1 = ram1[b_maddr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // One access on instance sel, checked cycle by cycle against the expected
    // timeline. After acceptance the request inputs are replaced by the next
    // request (nv=1 keeps valid high for back-to-back issue). Called and
    // returns on a falling edge.
    task automatic txn(input int sel, input bit w, input logic [AW-1:0] ad, input logic [DW-1:0] d,
                       input bit nv, input bit nw, input logic [AW-1:0] nad, input logic [DW-1:0] nd);
        int            sc  = (sel != 0) ? S1 : S0;
        int            tc  = (sel != 0) ? T1 : T0;
        int            lat = sc + tc + 2;
        int            wt  = 0;
        bit            vfy = 1'b0;
        bit            done = 1'b0;
        bit            exp_err;
        bit            e_we, e_re;
        logic [DW-1:0] exp_rd;
`ifdef RAM_ACCESS_CTRL_WR_VERIFY_EN
        vfy = w;
        if (w) lat = sc + 2 * tc + 3;
`endif
        valid[sel] = 1'b1; wr[sel] = w; addr[sel] = ad; wd[sel] = d;
        while (!v_rdy[sel] && wt < 50) begin
            @(negedge clk);
            wt++;
        end
        chk("accept_wait", 32'(wt < 50), 32'd1);
        @(posedge clk);
        #1;
        valid[sel] = nv; wr[sel] = nw; addr[sel] = nad; wd[sel] = nd;

        exp_rd  = model[sel][ad];
        exp_err = stuck0 && (sel == 0) && d[0];
        if (w) model[sel][ad] = (stuck0 && sel == 0) ? (d & 16'hFFFE) : d;

        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            e_we = w && (i >= sc) && (i < sc + tc);
            e_re = (!w && (i >= sc) && (i < sc + tc)) ||
                   (vfy && (i >= sc + tc + 1) && (i < sc + 2 * tc + 1));
            chk("we_re_exclusive", 32'(v_we[sel] & v_re[sel]), 32'd0);
            chk("mem_addr_held", 32'(v_maddr[sel]), 32'(ad));
            if (w) chk("mem_data_held", 32'(v_mdata[sel]), 32'(d));
            if (i < lat) begin
                chk("ready_busy", 32'(v_rdy[sel]), 32'd0);
                chk("resp_early", 32'(v_rv[sel]), 32'd0);
                chk("cs_window", 32'(v_cs[sel]), 32'(i < lat - 1));
                chk("we_window", 32'(v_we[sel]), 32'(e_we));
                chk("re_window", 32'(v_re[sel]), 32'(e_re));
            end else begin
                done = 1'b1;
                chk("resp_valid_lat", 32'(v_rv[sel]), 32'd1);
                chk("ready_idle", 32'(v_rdy[sel]), 32'd1);
                chk("cs_gap", 32'(v_cs[sel]), 32'd0);
                chk("resp_err", 32'(v_err[sel]), 32'(exp_err));
                if (!w) chk("resp_rdata", 32'(v_rdata[sel]), 32'(exp_rd));
            end
        end
        chk("resp_timeout", 32'(done), 32'd1);
    endtask

    logic          rw  [25];
    logic [AW-1:0] ra  [25];
    logic [DW-1:0] rdv [25];

    initial begin
        bit saw;

        // Reset state of both instances.
        #2;
        chk("rst_cs", 32'({a_cs, b_cs}), 32'd0);
        chk("rst_strobes", 32'({a_we, a_re, b_we, b_re}), 32'd0);
        chk("rst_resp", 32'({a_rv, a_err, b_rv, b_err}), 32'd0);
        chk("rst_addr", 32'({a_maddr, b_maddr}), 32'd0);
        chk("rst_data", 32'(a_mdata | b_mdata), 32'd0);
        chk("rst_rdata", 32'(a_rdata | b_rdata), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'({a_ready, b_ready}), 32'd3);

        // Write then read back.
        txn(0, 1'b1, 8'h3C, 16'hBEEF, 1'b0, 1'b0, 8'h00, 16'h0000);
        txn(0, 1'b0, 8'h3C, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);

        // Back-to-back writes with valid held high, then read them back.
        for (int k = 0; k < 4; k++)
            txn(0, 1'b1, 8'(k), 16'hA000 + 16'(k), k < 3, 1'b1, 8'(k + 1), 16'hA000 + 16'(k + 1));
        for (int k = 0; k < 4; k++)
            txn(0, 1'b0, 8'(k), 16'h0000, k < 3, 1'b0, 8'(k + 1), 16'h0000);

        // Inputs move to 0xFF while busy; only 0x21 may be written.
        txn(0, 1'b1, 8'h21, 16'h4321, 1'b0, 1'b1, 8'hFF, 16'hFFFF);
        txn(0, 1'b0, 8'hFF, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
        txn(0, 1'b0, 8'h21, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);

        // Reset during SETUP of a write: nothing reaches the RAM.
        txn(0, 1'b1, 8'h40, 16'h1234, 1'b0, 1'b0, 8'h00, 16'h0000);
        valid[0] = 1'b1; wr[0] = 1'b1; addr[0] = 8'h40; wd[0] = 16'hDEAD;
        @(posedge clk);
        #1 valid[0] = 1'b0;
        chk("setup_cs_before_rst", 32'(a_cs), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_cs", 32'(a_cs), 32'd0);
        chk("rst_mid_strobes", 32'({a_we, a_re}), 32'd0);
        chk("rst_mid_resp", 32'(a_rv), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        repeat (8) begin
            @(negedge clk);
            saw = saw | a_rv | a_we | a_re | a_cs;
        end
        chk("no_activity_after_rst", 32'(saw), 32'd0);
        txn(0, 1'b0, 8'h40, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);

`ifdef RAM_ACCESS_CTRL_WR_VERIFY_EN
        // Verify read-back: clean write, then a stuck-at-0 bit in the RAM.
        txn(0, 1'b1, 8'h10, 16'h5A5A, 1'b0, 1'b0, 8'h00, 16'h0000);
        stuck0 = 1'b1;
        txn(0, 1'b1, 8'h11, 16'h0001, 1'b0, 1'b0, 8'h00, 16'h0000);
        stuck0 = 1'b0;
`endif

        // SETUP_CYC=3, STROBE_CYC=1 instance.
        txn(1, 1'b1, 8'h05, 16'h7777, 1'b0, 1'b0, 8'h00, 16'h0000);
        txn(1, 1'b0, 8'h05, 16'h0000, 1'b1, 1'b0, 8'h06, 16'h0000);
        txn(1, 1'b0, 8'h06, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);

        // Randomized mix of reads/writes over a small address window.
        for (int k = 0; k < 25; k++) begin
            rw[k]  = 1'($urandom_range(0, 1));
            ra[k]  = 8'h20 + 8'($urandom_range(0, 7));
            rdv[k] = 16'($urandom);
        end
        for (int k = 0; k < 24; k++)
            txn(0, rw[k], ra[k], rdv[k], 1'($urandom_range(0, 1)), rw[k + 1], ra[k + 1], rdv[k + 1]);
        valid[0] = 1'b0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=hang expected=finish");
        $fatal(1, "timeout");
    end

endmodule
